// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-memory loader state encoding.
// Imported by imem_loader and word_assembler.
package cpu_pkg;

    localparam int CPU_ADDR_W = 10;
    localparam int CPU_DATA_W = 18;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_HI = 4'd1,
        ST_LEN_LO = 4'd2,
        ST_B0     = 4'd3,
        ST_B1     = 4'd4,
        ST_B2     = 4'd5,
        ST_WRITE  = 4'd6,
        ST_CHK    = 4'd7,
        ST_FIN    = 4'd8,
        ST_DONE   = 4'd9,
        ST_ERR    = 4'd10
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs three stream bytes into one 18-bit instruction word {B0[1:0], B1, B2}.
// word_valid pulses for one cycle after the third byte; word holds until the next one.
module word_assembler
    import cpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [CPU_DATA_W-1:0] word,
    output logic                  word_valid
);

    logic [1:0] byte_idx;
    logic [1:0] hi_bits;
    logic [7:0] mid_byte;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            byte_idx   <= 2'd0;
            hi_bits    <= 2'd0;
            mid_byte   <= 8'd0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                case (byte_idx)
                    2'd0: begin
                        hi_bits  <= byte_data[1:0];
                        byte_idx <= 2'd1;
                    end
                    2'd1: begin
                        mid_byte <= byte_data;
                        byte_idx <= 2'd2;
                    end
                    default: begin
                        word       <= {hi_bits, mid_byte, byte_data};
                        word_valid <= 1'b1;
                        byte_idx   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory, then pulses cpu_start.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state    | meaning
// IDLE     | waiting for load_req after reset
// LEN_HI   | receive word count high byte
// LEN_LO   | receive word count low byte, range check
// B0/B1/B2 | receive the three bytes of one word
// WRITE    | one imem write strobe, no byte accepted
// CHK      | receive checksum byte (checksum build only)
// FIN      | cpu_start pulse, done set
// DONE/ERR | sticky result, waiting for load_req
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = CPU_ADDR_W,
    parameter int DATA_W    = CPU_DATA_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned MAX_WORDS = (2 ** ADDR_W) - BASE_ADDR;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL_STATE = ST_CHK;
`else
    localparam loader_state_t TAIL_STATE = ST_FIN;
`endif

    loader_state_t state, state_next;
    logic [7:0]    len_hi;
    logic [15:0]   len;
    logic [15:0]   len_rx;
    logic          start_load;
    logic          asm_valid;
    logic [CPU_DATA_W-1:0] asm_word;
    logic          asm_word_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign len_rx    = {len_hi, in_data};
    assign asm_valid = in_valid && (state == ST_B0 || state == ST_B1 || state == ST_B2);

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_load),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        cpu_start  = 1'b0;
        busy       = 1'b1;
        start_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                busy = 1'b0;
                if (load_req) begin
                    start_load = 1'b1;
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Oversized images are rejected before any write so memory never wraps.
                    if (32'(len_rx) > MAX_WORDS) state_next = ST_ERR;
                    else if (len_rx == 16'd0)    state_next = TAIL_STATE;
                    else                         state_next = ST_B0;
                end
            end
            ST_B0: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_B1;
            end
            ST_B1: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_B2;
            end
            ST_B2: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we = asm_word_valid;
                if (32'(words_loaded) + 32'd1 == 32'(len)) state_next = TAIL_STATE;
                else                                       state_next = ST_B0;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_data == csum) ? ST_FIN : ST_ERR;
            end
`endif
            ST_FIN: begin
                cpu_start  = 1'b1;
                state_next = ST_DONE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_addr  = mem_we ? ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0] : '0;
    assign mem_wdata = mem_we ? DATA_W'(asm_word) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            len_hi       <= 8'd0;
            len          <= 16'd0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state <= state_next;
            if (start_load) begin
                len          <= 16'd0;
                words_loaded <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
            end
            if (state == ST_LEN_HI && in_valid) len_hi <= in_data;
            if (state == ST_LEN_LO && in_valid) len <= len_rx;
            if (mem_we) words_loaded <= words_loaded + 1'b1;
            if (state == ST_FIN) done <= 1'b1;
            if (state_next == ST_ERR && state != ST_ERR) error <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset || start_load) csum <= 8'd0;
        else if (in_ready && in_valid && state != ST_CHK) csum <= csum ^ in_data;
    end
`endif

endmodule
